f1_light_seq: RTL and testbench
===============================

# f1_light_seq

Parametrised F1 start-light sequencer. It lights WIDTH lamps one per enable tick, holds all lamps for a programmable number of ticks using an internal counter, then drives lights-out with a one-cycle `done` pulse. It adds abort and lamp-fill direction, and sits between the tick/clock-divider logic and the lamp driver / reaction timer.

## Interface
- `WIDTH`, default 8, number of lamps (≥2).
- `DELAY_W`, default 8, width of the hold-delay count.
- `FROM_MSB`, default 0: 0 fills lamps from bit 0 upward; 1 fills from bit WIDTH-1 downward.
- `clk` in 1: single clock, all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: tick strobe; advances FILL and HOLD.
- `trigger` in 1: starts a sequence; sampled in IDLE only.
- `abort` in 1: cancels any sequence; highest priority after `rst`.
- `delay_val` in DELAY_W: hold length in `en` ticks; latched on FILL→HOLD.
- `data_out` out WIDTH: lamp pattern.
- `cmd_seq` out 1: high while in FILL.
- `cmd_delay` out 1: one-cycle pulse in the first HOLD cycle.
- `done` out 1: high for exactly one cycle in OUT.
- `busy` out 1: high in FILL, HOLD and OUT.

## Operation
- States: IDLE, FILL, HOLD, OUT. Lamp count `n` ranges over 1..WIDTH. Hold counter `cnt` is DELAY_W bits wide.
- IDLE: `trigger`=1 → FILL with n=1. Otherwise stay in IDLE.
- FILL, `en`=1 and n<WIDTH: n←n+1.
- FILL, `en`=1 and n==WIDTH: → HOLD, cnt←`delay_val`.
- FILL, `en`=0: hold state.
- HOLD, cnt==0: → OUT on the next edge, regardless of `en`.
- HOLD, `en`=1 and cnt≠0: cnt←cnt-1.
- OUT: unconditionally → IDLE on the next edge.
- `abort`=1 in any state: → IDLE on that edge, n and cnt cleared. `abort` wins over `trigger` and `en`.
- `trigger` outside IDLE is ignored; it is not queued.
- `data_out` in FILL: the n lowest bits are set (FROM_MSB=0) or the n highest bits are set (FROM_MSB=1).
- `data_out` in HOLD: all ones.
- `data_out` in IDLE and OUT: zero.
- All outputs are Moore, decoded from registered state only. Outputs have no combinational path from the inputs.
- The delay arithmetic is unsigned and never wraps: the counter does not decrement below 0.

## Timing
- Reset values: state IDLE, n=0, cnt=0. `data_out`=0, `cmd_seq`=0, `cmd_delay`=0, `done`=0, `busy`=0.
- `rst` asserted mid-sequence returns the block to reset values on that edge. `rst` overrides `abort`.
- Trigger latency: `trigger` sampled at edge k gives first lamp lit and `cmd_seq`=1 after edge k.
- With `en` held high, the sequence takes WIDTH+`delay_val`+2 edges from trigger to OUT, then one more edge to IDLE.
- `delay_val`=0: HOLD lasts one cycle, then OUT.
- Changes to `delay_val` after the FILL→HOLD edge have no effect on the current sequence.
- Back-to-back sequences: `trigger` high in the IDLE cycle directly after OUT starts a new sequence. The minimum gap is one IDLE cycle.

## Structure
- Package `f1_pkg` holds:
  - the `f1_state_t` enum (IDLE, FILL, HOLD, OUT), 2-bit encoding;
  - the default WIDTH and DELAY_W localparams.
- Sub-module `f1_delay_cnt` is a loadable down-counter with enable and a zero flag. It serves HOLD and is reusable by the reaction timer.
- The top level contains the state register, the lamp count and the output decode.

## Test plan
- **Basic sequence.** WIDTH=8, FROM_MSB=0, `en`=1 constantly, `delay_val`=3, `trigger` pulse at edge 0.
  - `data_out` = 0x01, 0x03 … 0xFF after edges 0–7.
  - HOLD after edge 8, with `cmd_delay`=1 for one cycle.
  - 0xFF held through edge 11; OUT after edge 12 with `data_out`=0x00 and `done`=1; IDLE after edge 13.
- **Reverse fill, zero delay, gated ticks.** FROM_MSB=1, `delay_val`=0, `en` every 3rd cycle.
  - Pattern steps 0x80, 0xC0 … 0xFF only on `en` cycles.
  - HOLD lasts exactly one cycle, then `done`.
- **Abort.** Assert `abort` with 5 lamps lit, simultaneously with `en`=1.
  - IDLE next cycle: `data_out`=0, `busy`=0, no `done`.
  - A later `trigger` restarts from 0x01.
- **Ignored trigger.** Pulse `trigger` during FILL and HOLD.
  - Sequence timing is unchanged and exactly one `done` is produced.
  - Change `delay_val` mid-HOLD: no effect.
- **Reset.** Assert `rst` in HOLD: all outputs are 0 after that edge.
  - `trigger` and `abort` high together in IDLE: block stays in IDLE.
- **Back-to-back.** `trigger` held high continuously.
  - Sequences repeat with exactly one IDLE cycle between OUT and the next 0x01.
  - Check `busy` and `done` counts over 3 runs.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and default sizes for the F1 start-light sequencer.
package f1_pkg;

   localparam int F1_WIDTH_DEF   = 8;
   localparam int F1_DELAY_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2,
      OUT  = 2'd3
   } f1_state_t;

endpackage

// File: rtl/f1_delay_cnt.sv
// Loadable down-counter with enable and zero flag; saturates at zero.
module f1_delay_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear beats load beats decrement; never decrement past zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - W'(1);
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fills lamps one per tick, holds, then lights out.
//
// state | meaning
// IDLE  | lamps dark, waiting for trigger
// FILL  | one more lamp lit per en tick until all WIDTH are lit
// HOLD  | all lamps lit while the hold counter runs down
// OUT   | lights out, single-cycle done
module f1_light_seq
   import f1_pkg::*;
#(
   parameter int WIDTH    = F1_WIDTH_DEF,
   parameter int DELAY_W  = F1_DELAY_W_DEF,
   parameter bit FROM_MSB = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               trigger,
   input  logic               abort,
   input  logic [DELAY_W-1:0] delay_val,
   output logic [WIDTH-1:0]   data_out,
   output logic               cmd_seq,
   output logic               cmd_delay,
   output logic               done,
   output logic               busy
);

   localparam int            NW     = $clog2(WIDTH + 1);
   localparam logic [NW-1:0] N_FULL = NW'(WIDTH);

   f1_state_t     state_q, state_d;
   logic [NW-1:0] n_q, n_d;
   logic          first_q, first_d;
   logic          cnt_clr, cnt_load, cnt_dec, cnt_zero;
   logic [WIDTH-1:0] lamps;

   // delay_val is only sampled on the load, so later changes cannot disturb HOLD.
   f1_delay_cnt #(.W(DELAY_W)) u_delay_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (delay_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Next-state logic; abort overrides every state and input.
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      first_d  = 1'b0;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (abort) begin
         state_d = IDLE;
         n_d     = '0;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d = FILL;
                  n_d     = NW'(1);
               end
            end
            FILL: begin
               if (en) begin
                  if (n_q == N_FULL) begin
                     state_d  = HOLD;
                     cnt_load = 1'b1;
                     first_d  = 1'b1;
                  end else begin
                     n_d = n_q + NW'(1);
                  end
               end
            end
            HOLD: begin
               if (cnt_zero)
                  state_d = OUT;
               else if (en)
                  cnt_dec = 1'b1;
            end
            OUT: begin
               state_d = IDLE;
               n_d     = '0;
            end
            default: begin
               state_d = IDLE;
               n_d     = '0;
            end
         endcase
      end
   end

   // State, lamp count and first-HOLD-cycle flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         first_q <= first_d;
      end
   end

   // Fill pattern for n lit lamps, from the selected end.
   always_comb begin
      lamps = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (FROM_MSB)
            lamps[i] = (NW'(i) >= (N_FULL - n_q));
         else
            lamps[i] = (NW'(i) < n_q);
      end
   end

   // Moore output decode from registered state only.
   always_comb begin
      data_out  = '0;
      cmd_seq   = 1'b0;
      cmd_delay = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      case (state_q)
         FILL: begin
            data_out = lamps;
            cmd_seq  = 1'b1;
            busy     = 1'b1;
         end
         HOLD: begin
            data_out  = '1;
            cmd_delay = first_q;
            busy      = 1'b1;
         end
         OUT: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_f1_light_seq.sv
// Bench for f1_light_seq: directed scenarios plus random stimulus against a lamp/hold model.
module tb_f1_light_seq;

   logic       clk = 1'b0;
   logic       rst, en, trigger, abort;
   logic [7:0] delay_val;

   logic [7:0] data0, data1;
   logic       seq0, dly0, done0, busy0;
   logic       seq1, dly1, done1, busy1;

   int errors = 0;
   int checks = 0;

   // Model: lamps lit, holding flag with remaining ticks, lights-out flag, first-hold flag.
   int m_lit, m_hold, m_rem, m_out, m_first;

   always #5 clk = ~clk;

   f1_light_seq #(.WIDTH(8), .DELAY_W(8), .FROM_MSB(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
      .delay_val(delay_val), .data_out(data0), .cmd_seq(seq0),
      .cmd_delay(dly0), .done(done0), .busy(busy0)
   );

   f1_light_seq #(.WIDTH(8), .DELAY_W(8), .FROM_MSB(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
      .delay_val(delay_val), .data_out(data1), .cmd_seq(seq1),
      .cmd_delay(dly1), .done(done1), .busy(busy1)
   );

   function automatic int fill_pat(int lit, bit msb);
      int p;
      p = (1 << lit) - 1;
      if (msb) p = (p << (8 - lit)) & 8'hFF;
      return p;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      int nl, nh, nr, no, nf;
      nl = m_lit; nh = m_hold; nr = m_rem; no = 0; nf = 0;
      if (rst || abort) begin
         nl = 0; nh = 0; nr = 0;
      end else if (m_out != 0) begin
         nl = 0;
      end else if (m_hold != 0) begin
         if (m_rem == 0) begin
            nh = 0; no = 1;
         end else if (en) begin
            nr = m_rem - 1;
         end
      end else if (m_lit > 0) begin
         if (en) begin
            if (m_lit < 8) nl = m_lit + 1;
            else begin
               nl = 0; nh = 1; nr = int'(delay_val); nf = 1;
            end
         end
      end else if (trigger) begin
         nl = 1;
      end
      m_lit = nl; m_hold = nh; m_rem = nr; m_out = no; m_first = nf;
   endtask

   task automatic check_all();
      int e0, e1;
      e0 = (m_hold != 0) ? 8'hFF : ((m_lit > 0) ? fill_pat(m_lit, 1'b0) : 0);
      e1 = (m_hold != 0) ? 8'hFF : ((m_lit > 0) ? fill_pat(m_lit, 1'b1) : 0);
      check("data_lsb", 32'(data0), 32'(e0));
      check("data_msb", 32'(data1), 32'(e1));
      check("cmd_seq", 32'(seq0), 32'(m_lit > 0));
      check("cmd_delay", 32'(dly0), 32'(m_first));
      check("done", 32'(done0), 32'(m_out));
      check("busy", 32'(busy0), 32'((m_lit > 0) || (m_hold != 0) || (m_out != 0)));
      check("done_msb", 32'(done1), 32'(m_out));
      check("busy_msb", 32'(busy1), 32'((m_lit > 0) || (m_hold != 0) || (m_out != 0)));
   endtask

   task automatic step(input bit rs, input bit tr, input bit ab, input bit e, input logic [7:0] dv);
      rst = rs; trigger = tr; abort = ab; en = e; delay_val = dv;
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   initial begin
      int n_done, n_busy;
      m_lit = 0; m_hold = 0; m_rem = 0; m_out = 0; m_first = 0;
      rst = 1'b1; trigger = 1'b0; abort = 1'b0; en = 1'b0; delay_val = 8'd0;

      // Reset state
      step(1, 0, 0, 0, 8'd0);
      step(1, 1, 0, 1, 8'd5);
      check("rst_data", 32'(data0), 32'h0);
      check("rst_busy", 32'(busy0), 32'h0);
      step(0, 0, 0, 1, 8'd3);

      // Basic sequence: trigger at edge 0, en high, delay 3
      step(0, 1, 0, 1, 8'd3);
      check("basic_first_lamp", 32'(data0), 32'h01);
      for (int k = 1; k <= 13; k++) begin
         step(0, 0, 0, 1, 8'd3);
         if (k == 7)  check("basic_full", 32'(data0), 32'hFF);
         if (k == 8)  check("basic_cmd_delay", 32'(dly0), 32'h1);
         if (k == 11) check("basic_hold_end", 32'(data0), 32'hFF);
         if (k == 12) check("basic_done", 32'(done0), 32'h1);
         if (k == 13) check("basic_idle", 32'(busy0), 32'h0);
      end

      // Reverse fill, zero delay, en every third cycle
      step(0, 1, 0, 0, 8'd0);
      check("rev_first_lamp", 32'(data1), 32'h80);
      for (int k = 1; k <= 30; k++) step(0, 0, 0, (k % 3) == 0, 8'd0);

      // Abort with five lamps lit, simultaneous with en
      step(0, 1, 0, 0, 8'd4);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 8'd4);
      check("abort_five_lamps", 32'(data0), 32'h1F);
      step(0, 0, 1, 1, 8'd4);
      check("abort_busy", 32'(busy0), 32'h0);
      check("abort_done", 32'(done0), 32'h0);
      step(0, 0, 0, 1, 8'd4);
      step(0, 1, 0, 1, 8'd4);
      check("abort_restart", 32'(data0), 32'h01);
      step(0, 0, 1, 0, 8'd4);

      // Ignored trigger during FILL/HOLD, delay_val changed mid-HOLD
      step(0, 1, 0, 1, 8'd5);
      n_done = 0;
      for (int k = 1; k <= 20; k++) begin
         step(0, (k <= 12) && ((k % 2) == 0), 0, 1, (k >= 10) ? 8'd200 : 8'd5);
         if (done0) n_done++;
         if (k == 14) check("ign_done_edge", 32'(done0), 32'h1);
      end
      check("ign_done_count", 32'(n_done), 32'd1);

      // Reset in HOLD; trigger with abort in IDLE
      step(0, 1, 0, 1, 8'd9);
      for (int k = 0; k < 9; k++) step(0, 0, 0, 1, 8'd9);
      check("pre_rst_hold", 32'(data0), 32'hFF);
      step(1, 0, 1, 1, 8'd9);
      check("rst_hold_data", 32'(data0), 32'h0);
      check("rst_hold_busy", 32'(busy0), 32'h0);
      step(0, 1, 1, 1, 8'd9);
      check("trig_abort_idle", 32'(busy0), 32'h0);

      // Back-to-back with trigger held high, three runs
      n_done = 0; n_busy = 0;
      for (int k = 1; k <= 42; k++) begin
         step(0, 1, 0, 1, 8'd3);
         if (done0) n_done++;
         if (busy0) n_busy++;
         if (k == 14 || k == 28) check("b2b_gap", 32'(busy0), 32'h0);
      end
      check("b2b_done_count", 32'(n_done), 32'd3);
      check("b2b_busy_count", 32'(n_busy), 32'd39);

      // Random stimulus against the model
      for (int k = 0; k < 600; k++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
              8'($urandom_range(0, 12)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
